// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath: opcodes, FSM states and
// the mux/ALU control codes consumed by the datapath and ALUControl.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with memory-ready handshaking,
// retire pulse/counter and illegal-opcode detection.
module multicycle_control
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSrc,
  output logic        PCEn,
  output logic [3:0]  State,
  output logic        InstrDone,
  output logic        IllegalOp,
  output logic [31:0] InstrCount
);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mem_rd, mem_wr, ir_wr, pc_wr, branch, reg_wr, done, illegal;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    IorD     = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    branch   = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    reg_wr   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    ALUOp    = ALUOP_ADD;
    PCSrc    = PCSRC_ALU;
    done     = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd  = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ir_wr   = MemReady;
        pc_wr   = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        illegal = ~is_supported(Opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        IorD   = 1'b1;
        mem_rd = 1'b1;
      end
      S_MEMWB: begin
        reg_wr   = 1'b1;
        MemtoReg = 1'b1;
        done     = 1'b1;
      end
      S_MEMWR: begin
        IorD   = 1'b1;
        mem_wr = 1'b1;
        done   = MemReady;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_wr = 1'b1;
        RegDst = 1'b1;
        done   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
        done    = 1'b1;
      end
      S_ADDIWB: begin
        reg_wr = 1'b1;
        done   = 1'b1;
      end
      S_JUMP: begin
        PCSrc = PCSRC_JUMP;
        pc_wr = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every strobe so an abandoned instruction cannot write anything.
  assign MemRead   = mem_rd  & ~reset;
  assign MemWrite  = mem_wr  & ~reset;
  assign IRWrite   = ir_wr   & ~reset;
  assign RegWrite  = reg_wr  & ~reset;
  assign InstrDone = done    & ~reset;
  assign IllegalOp = illegal & ~reset;
  assign PCEn      = (pc_wr | (branch & Zero)) & ~reset;

  assign cnt_d = InstrDone ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= 32'd0;
    else       cnt_q <= cnt_d;
  end

  assign State      = state_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control with directed corner cases.
module tb_multicycle_control;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset, Zero, MemReady;
  logic [5:0]  Opcode;
  logic        IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSrc;
  logic        PCEn, InstrDone, IllegalOp;
  logic [3:0]  State;
  logic [31:0] InstrCount;

  multicycle_control dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .State(State),
    .InstrDone(InstrDone), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cycles;
    logic        illegal;
    logic [31:0] cnt;
    logic [31:0] pathsig;
    int          regwr, pcen, memwr, memrd;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0, failures = 0;
  logic [31:0] mdl_cnt = 32'd0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit supported(input logic [5:0] op);
    return op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd8 || op == 6'd35 || op == 6'd43;
  endfunction

  // State sequence of each instruction class, straight from the instruction paths.
  function automatic void path_of(input logic [5:0] op, output int p[5], output int n);
    p = '{0, 1, 0, 0, 0};
    n = 2;
    case (op)
      6'd0:    begin p[2] = 6; p[3] = 7;            n = 4; end
      6'd35:   begin p[2] = 2; p[3] = 3; p[4] = 4;  n = 5; end
      6'd43:   begin p[2] = 2; p[3] = 5;            n = 4; end
      6'd4:    begin p[2] = 8;                      n = 3; end
      6'd8:    begin p[2] = 9; p[3] = 10;           n = 4; end
      6'd2:    begin p[2] = 11;                     n = 3; end
      default: ;
    endcase
  endfunction

  // f = fetch stall cycles, m = memory stall cycles, bz = forced Zero (-1 random).
  task automatic run_instr(input logic [5:0] op, input int f, input int m, input int bz);
    exp_t e;
    int   p[5];
    int   n, reps;
    bit   stall;
    logic mr[$], zr[$];
    logic [5:0] oq[$];
    logic z;
    path_of(op, p, n);
    e = '{cycles: 0, illegal: 1'b0, cnt: 32'd0, pathsig: 32'd0,
          regwr: 0, pcen: 0, memwr: 0, memrd: 0};
    for (int k = 0; k < n; k++) begin
      e.pathsig = {e.pathsig[27:0], 4'(p[k])};
      stall = (p[k] == 0) || (p[k] == 3) || (p[k] == 5);
      reps  = (p[k] == 0) ? f + 1 : ((p[k] == 3 || p[k] == 5) ? m + 1 : 1);
      for (int r = 0; r < reps; r++) begin
        z = (bz >= 0) ? bz[0] : 1'($urandom_range(0, 1));
        mr.push_back(stall ? (r == reps - 1) : 1'($urandom_range(0, 1)));
        zr.push_back(z);
        oq.push_back(p[k] == 0 ? 6'($urandom_range(0, 63)) : op);
        if (p[k] == 8 && z) e.pcen++;
      end
    end
    e.cycles  = mr.size();
    e.illegal = !supported(op);
    e.pcen   += 1 + ((op == 6'd2) ? 1 : 0);
    e.regwr   = (op == 6'd0 || op == 6'd35 || op == 6'd8) ? 1 : 0;
    e.memwr   = (op == 6'd43) ? m + 1 : 0;
    e.memrd   = f + 1 + ((op == 6'd35) ? m + 1 : 0);
    if (!e.illegal) mdl_cnt = mdl_cnt + 32'd1;
    e.cnt = mdl_cnt;
    sbq.push_back(e);
    for (int i = 0; i < mr.size(); i++) begin
      Opcode   = oq[i];
      MemReady = mr[i];
      Zero     = zr[i];
      @(posedge clock); #1;
    end
  endtask

  // Monitor: per-state decode checks plus per-instruction scoreboard compare.
  int          m_cyc = 0, m_rw = 0, m_pcen = 0, m_mw = 0, m_mr = 0, m_last = -1;
  logic [31:0] m_sig = 32'd0, m_pend_cnt = 32'd0;
  bit          m_pend = 1'b0;
  exp_t        m_e;

  always @(negedge clock) begin
    if (reset) begin
      m_cyc = 0; m_rw = 0; m_pcen = 0; m_mw = 0; m_mr = 0; m_last = -1;
      m_sig = 32'd0; m_pend = 1'b0;
    end else begin
      if (m_pend) chk("count", InstrCount, m_pend_cnt);
      m_pend = 1'b0;
      m_cyc++;
      m_rw   += int'(RegWrite);
      m_pcen += int'(PCEn);
      m_mw   += int'(MemWrite);
      m_mr   += int'(MemRead);
      if (int'(State) != m_last) begin
        m_sig  = {m_sig[27:0], State};
        m_last = int'(State);
      end
      case (State)
        4'd0: chk("fetch_dec", {IorD, MemRead, ALUSrcA, ALUSrcB, ALUOp, PCSrc, IRWrite, PCEn},
                  {1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, MemReady, MemReady});
        4'd1: chk("decode_dec", {ALUSrcA, ALUSrcB, ALUOp}, {1'b0, 2'b11, 2'b00});
        4'd2, 4'd9: chk("adr_dec", {ALUSrcA, ALUSrcB, ALUOp}, {1'b1, 2'b10, 2'b00});
        4'd3: chk("memrd_dec", {IorD, MemRead, MemWrite}, 3'b110);
        4'd4: chk("memwb_dec", {RegWrite, RegDst, MemtoReg}, 3'b101);
        4'd5: chk("memwr_dec", {IorD, MemWrite, MemRead}, 3'b110);
        4'd6: chk("exec_dec", {ALUSrcA, ALUSrcB, ALUOp}, {1'b1, 2'b00, 2'b10});
        4'd7: chk("aluwb_dec", {RegWrite, RegDst, MemtoReg}, 3'b110);
        4'd8: chk("branch_dec", {ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn},
                  {1'b1, 2'b00, 2'b01, 2'b01, Zero});
        4'd10: chk("addiwb_dec", {RegWrite, RegDst, MemtoReg}, 3'b100);
        4'd11: chk("jump_dec", {PCSrc, PCEn}, {2'b10, 1'b1});
        default: chk("state_range", State, 4'd0);
      endcase
      if (InstrDone || IllegalOp) begin
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_retire state=%0d", State);
        end else begin
          m_e = sbq.pop_front();
          chk("cycles",  m_cyc,     m_e.cycles);
          chk("path",    m_sig,     m_e.pathsig);
          chk("illegal", IllegalOp, m_e.illegal);
          chk("regwr",   m_rw,      m_e.regwr);
          chk("pcen",    m_pcen,    m_e.pcen);
          chk("memwr",   m_mw,      m_e.memwr);
          chk("memrd",   m_mr,      m_e.memrd);
          m_pend = 1'b1;
          m_pend_cnt = m_e.cnt;
        end
        m_cyc = 0; m_rw = 0; m_pcen = 0; m_mw = 0; m_mr = 0; m_last = -1; m_sig = 32'd0;
      end else if (m_cyc > 40) begin
        failures++;
        $display("FAIL retire_timeout cycles=%0d state=%0d", m_cyc, State);
        m_cyc = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog state=%0d", State);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  logic [5:0] rop;
  logic [5:0] ops[6] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2};

  initial begin
    reset = 1'b1; MemReady = 1'b1; Opcode = 6'd0; Zero = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("rst_strobes", {PCEn, IRWrite, MemWrite, MemRead, RegWrite, InstrDone, IllegalOp}, 7'd0);
    @(posedge clock); @(negedge clock);
    chk("rst_state", State, 4'd0);
    chk("rst_count", InstrCount, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    run_instr(6'd0, 0, 0, -1);   // R-type straight after reset
    run_instr(6'd35, 0, 2, -1);  // lw with two memory stalls
    run_instr(6'd4, 0, 0, 1);    // beq taken
    run_instr(6'd4, 0, 0, 0);    // beq not taken
    run_instr(6'd63, 0, 0, -1);  // illegal
    run_instr(6'd43, 1, 1, -1);

    // Abandon a store mid-MEMWR via reset.
    Opcode = 6'd43; MemReady = 1'b1; Zero = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    MemReady = 1'b0;
    @(negedge clock);
    chk("memwr_before_rst", {State, MemWrite}, {4'd5, 1'b1});
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("memwr_in_rst", MemWrite, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("state_after_rst", State, 4'd0);
    chk("count_after_rst", InstrCount, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Counter wrap on a jump.
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    mdl_cnt = 32'hFFFF_FFFF;
    run_instr(6'd2, 0, 0, -1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rop = 6'($urandom_range(0, 63));
      end else begin
        rop = ops[$urandom_range(0, 5)];
      end
      run_instr(rop, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
    end

    MemReady = 1'b0;
    repeat (3) @(negedge clock);
    chk("drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
